// File: rtl/multi_timer.sv
// multi_timer: bus-mapped block of up to four prescaled up-counters sharing
// one 16-bit free-running divider.
//
// Register window (byte offsets from BASE):
//   +0            DIV     divider[15:8]; any write clears the whole divider
//   +8+8c+0       CNT_LO  counter byte 0
//   +8+8c+1       CNT_HI  counter byte 1 (reads 0, writes ignored when WIDTH=8)
//   +8+8c+2       RLD_LO  reload byte 0
//   +8+8c+3       RLD_HI  reload byte 1 (reads 0, writes ignored when WIDTH=8)
//   +8+8c+4       CTRL    [2:0] SEL, [3] EN, [4] ONESHOT, [5] IRQEN
//   +8+8c+5       STAT    [0] pending, write-1-to-clear
//   anything else reads 00 and ignores writes.
//
// Ports:
//   clockgb       system clock, all state changes on its rising edge
//   resetn        synchronous active-low reset
//   address       bus byte address
//   indata        bus write data
//   outdata       combinational read data (00 unless load=1 and mapped)
//   load          bus read strobe
//   store         bus write strobe, sampled on the clock edge
//   overflow_int  level interrupt: OR over channels of pending & IRQEN
//
// Bus handshake: there is no flow control. A write is accepted on every
// rising edge where store=1 and resetn=1; a read is answered in the same
// cycle whenever load=1. Written values are visible from the next cycle.
//
// Build option: define MULTI_TIMER_DIV_GLITCH_EN to let a DIV write produce
// a tick on every channel whose tapped divider bit is 1 at that moment
// (the bit falls to 0 because of the clear). Without it a DIV write never
// produces a tick.

module multi_timer #(
  parameter logic [15:0] BASE  = 16'hff04,
  parameter int          NCH   = 2,
  parameter int          WIDTH = 8
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic        overflow_int
);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [15:0] offset;
  logic        div_hit;
  logic        div_wr;

  // Offsets wrap modulo 2^16, so a BASE near the top of the map still works.
  assign offset  = address - BASE;
  assign div_hit = (offset == 16'h0000);
  assign div_wr  = store & div_hit;

  // ---------------------------------------------------------------------
  // Free-running divider
  // ---------------------------------------------------------------------
  logic [15:0] div_q;
  logic [15:0] div_inc;

  assign div_inc = div_q + 16'd1;

  always_ff @(posedge clockgb) begin
    if (!resetn) begin
      div_q <= 16'h0000;
    end else if (div_wr) begin
      div_q <= 16'h0000;
    end else begin
      div_q <= div_inc;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------
  logic [NCH-1:0] ch_hit;
  logic [NCH-1:0] ch_irq;
  logic [7:0]     ch_rd [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] rld_q;
    logic [5:0]       ctrl_q;
    logic             pend_q;

    logic [15:0]      cnt16;
    logic [15:0]      rld16;
    logic [15:0]      cnt_wdata;
    logic [15:0]      rld_wdata;
    logic             wr_cnt_lo;
    logic             wr_cnt_hi;
    logic             wr_rld_lo;
    logic             wr_rld_hi;
    logic             wr_ctrl;
    logic             wr_stat;
    logic [3:0]       tap;
    logic             tick;
    logic             cnt_full;
    logic             ovf;

    // Channel c occupies offsets 8+8c .. 8+8c+7.
    assign ch_hit[c] = (offset[15:3] == 13'(c + 1));

    assign wr_cnt_lo = store & ch_hit[c] & (offset[2:0] == 3'd0);
    assign wr_cnt_hi = store & ch_hit[c] & (offset[2:0] == 3'd1) & (WIDTH == 16);
    assign wr_rld_lo = store & ch_hit[c] & (offset[2:0] == 3'd2);
    assign wr_rld_hi = store & ch_hit[c] & (offset[2:0] == 3'd3) & (WIDTH == 16);
    assign wr_ctrl   = store & ch_hit[c] & (offset[2:0] == 3'd4);
    assign wr_stat   = store & ch_hit[c] & (offset[2:0] == 3'd5);

    // 16-bit views keep the byte lanes uniform for both widths; the upper
    // byte of the view is zero when WIDTH=8.
    assign cnt16     = 16'(cnt_q);
    assign rld16     = 16'(rld_q);
    assign cnt_wdata = wr_cnt_hi ? {indata, cnt16[7:0]} : {cnt16[15:8], indata};
    assign rld_wdata = wr_rld_hi ? {indata, rld16[7:0]} : {rld16[15:8], indata};

    // Tap bit k = 2*SEL+1; a tick is its falling edge across this cycle.
    assign tap = {ctrl_q[2:0], 1'b1};

    always_comb begin
      tick = div_q[tap] & ~div_inc[tap];
      if (div_wr) begin
`ifdef MULTI_TIMER_DIV_GLITCH_EN
        // The clear drops the tapped bit to 0 if it was 1.
        tick = div_q[tap];
`else
        tick = 1'b0;
`endif
      end
    end

    assign cnt_full = (cnt_q == {WIDTH{1'b1}});
    // A counter-byte write in the same cycle suppresses the overflow.
    assign ovf = tick & ctrl_q[3] & cnt_full & ~wr_cnt_lo & ~wr_cnt_hi;

    always_ff @(posedge clockgb) begin
      if (!resetn) begin
        cnt_q  <= '0;
        rld_q  <= '0;
        ctrl_q <= 6'd0;
        pend_q <= 1'b0;
      end else begin
        if (wr_cnt_lo || wr_cnt_hi) begin
          cnt_q <= cnt_wdata[WIDTH-1:0];
        end else if (tick && ctrl_q[3]) begin
          if (cnt_full) begin
            cnt_q <= rld_q;
          end else begin
            cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end

        if (wr_rld_lo || wr_rld_hi) begin
          rld_q <= rld_wdata[WIDTH-1:0];
        end

        if (wr_ctrl) begin
          ctrl_q <= indata[5:0];
        end else if (ovf && ctrl_q[4]) begin
          ctrl_q[3] <= 1'b0;
        end

        // Set beats clear when both land on the same edge.
        if (ovf) begin
          pend_q <= 1'b1;
        end else if (wr_stat && indata[0]) begin
          pend_q <= 1'b0;
        end
      end
    end

    always_comb begin
      ch_rd[c] = 8'h00;
      case (offset[2:0])
        3'd0:    ch_rd[c] = cnt16[7:0];
        3'd1:    ch_rd[c] = cnt16[15:8];
        3'd2:    ch_rd[c] = rld16[7:0];
        3'd3:    ch_rd[c] = rld16[15:8];
        3'd4:    ch_rd[c] = {2'b00, ctrl_q};
        3'd5:    ch_rd[c] = {7'd0, pend_q};
        default: ch_rd[c] = 8'h00;
      endcase
    end

    assign ch_irq[c] = pend_q & ctrl_q[5];
  end

  // ---------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------
  always_comb begin
    outdata = 8'h00;
    if (load) begin
      if (div_hit) begin
        outdata = div_q[15:8];
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_hit[c]) begin
          outdata = ch_rd[c];
        end
      end
    end
  end

  assign overflow_int = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: drives one 8-bit and one 16-bit multi_timer from the same
// bus and compares both against an arithmetic reference model.

module tb_multi_timer;

  localparam logic [15:0] BASE = 16'hff04;
  localparam int          NCH  = 2;
`ifdef MULTI_TIMER_DIV_GLITCH_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------
  logic        clockgb = 1'b0;
  logic        resetn  = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  indata  = 8'h00;
  logic        load    = 1'b0;
  logic        store   = 1'b0;
  logic [7:0]  out8;
  logic [7:0]  out16;
  logic        irq8;
  logic        irq16;

  always #5 clockgb = ~clockgb;

  multi_timer #(.BASE(BASE), .NCH(NCH), .WIDTH(8)) u_dut8 (
    .clockgb      (clockgb),
    .resetn       (resetn),
    .address      (address),
    .indata       (indata),
    .outdata      (out8),
    .load         (load),
    .store        (store),
    .overflow_int (irq8)
  );

  multi_timer #(.BASE(BASE), .NCH(NCH), .WIDTH(16)) u_dut16 (
    .clockgb      (clockgb),
    .resetn       (resetn),
    .address      (address),
    .indata       (indata),
    .outdata      (out16),
    .load         (load),
    .store        (store),
    .overflow_int (irq16)
  );

  // ---------------------------------------------------------------------
  // Scoreboard counters and check task
  // ---------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: index 0 = WIDTH 8 instance, index 1 = WIDTH 16
  // ---------------------------------------------------------------------
  int unsigned m_div;
  int unsigned m_cnt  [2][NCH];
  int unsigned m_rld  [2][NCH];
  int unsigned m_ctrl [2][NCH];
  bit          m_pend [2][NCH];

  function automatic int unsigned width_of(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int unsigned off_of(input logic [15:0] a);
    logic [15:0] o;
    o = a - BASE;
    return int'(o);
  endfunction

  task automatic model_step(input bit rn, input logic [15:0] a, input logic [7:0] d, input bit st);
    int unsigned off, r, k, period, mask, w;
    bit div_wr, tick, hit, wlo, whi, ovf, en;
    if (!rn) begin
      m_div = 0;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < NCH; c++) begin
          m_cnt[i][c] = 0; m_rld[i][c] = 0; m_ctrl[i][c] = 0; m_pend[i][c] = 0;
        end
      end
      return;
    end
    off    = off_of(a);
    r      = off % 8;
    div_wr = st && (off == 0);
    for (int i = 0; i < 2; i++) begin
      w    = width_of(i);
      mask = (1 << w) - 1;
      for (int c = 0; c < NCH; c++) begin
        k      = 2 * (m_ctrl[i][c] & 7) + 1;
        period = 1 << (k + 1);
        if (div_wr) tick = GLITCH && (((m_div >> k) & 1) == 1);
        else        tick = (m_div % period) == period - 1;
        en  = (m_ctrl[i][c] & 8) != 0;
        hit = st && (off >= 8) && ((off - 8) / 8 == c);
        wlo = hit && (r == 0);
        whi = hit && (r == 1) && (w == 16);
        ovf = tick && en && (m_cnt[i][c] == mask) && !wlo && !whi;
        if (wlo)              m_cnt[i][c] = (m_cnt[i][c] & 32'hff00) | d;
        else if (whi)         m_cnt[i][c] = (m_cnt[i][c] & 32'h00ff) | (int'(d) << 8);
        else if (tick && en)  m_cnt[i][c] = ovf ? m_rld[i][c] : ((m_cnt[i][c] + 1) & mask);
        if (hit && r == 2)            m_rld[i][c] = (m_rld[i][c] & 32'hff00) | d;
        if (hit && r == 3 && w == 16) m_rld[i][c] = (m_rld[i][c] & 32'h00ff) | (int'(d) << 8);
        if (hit && r == 4)               m_ctrl[i][c] = d & 8'h3f;
        else if (ovf && (m_ctrl[i][c] & 16) != 0) m_ctrl[i][c] = m_ctrl[i][c] & ~32'd8;
        if (ovf)                     m_pend[i][c] = 1'b1;
        else if (hit && r == 5 && d[0]) m_pend[i][c] = 1'b0;
      end
    end
    m_div = div_wr ? 0 : ((m_div + 1) & 32'hffff);
  endtask

  function automatic logic [7:0] model_rd(input int i, input logic [15:0] a);
    int unsigned off, c;
    off = off_of(a);
    if (off == 0) return 8'(m_div >> 8);
    if (off < 8 || off >= 8 + 8 * NCH) return 8'h00;
    c = (off - 8) / 8;
    case (off % 8)
      0: return 8'(m_cnt[i][c]);
      1: return 8'(m_cnt[i][c] >> 8);
      2: return 8'(m_rld[i][c]);
      3: return 8'(m_rld[i][c] >> 8);
      4: return 8'(m_ctrl[i][c]);
      5: return {7'd0, m_pend[i][c]};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_irq(input int i);
    logic v;
    v = 1'b0;
    for (int c = 0; c < NCH; c++) v |= m_pend[i][c] && ((m_ctrl[i][c] & 32) != 0);
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks: one bus cycle, then check outputs 1 ns after the edge
  // ---------------------------------------------------------------------
  task automatic cyc(input bit rn, input logic [15:0] a, input logic [7:0] d, input bit ld, input bit st);
    resetn  = rn;
    address = a;
    indata  = d;
    load    = ld;
    store   = st;
    @(posedge clockgb);
    model_step(rn, a, d, st);
    #1;
    check("irq_w8", {15'd0, irq8}, {15'd0, model_irq(0)});
    check("irq_w16", {15'd0, irq16}, {15'd0, model_irq(1)});
    check($sformatf("rd_w8_%h", a), {8'd0, out8}, {8'd0, ld ? model_rd(0, a) : 8'h00});
    check($sformatf("rd_w16_%h", a), {8'd0, out16}, {8'd0, ld ? model_rd(1, a) : 8'h00});
  endtask

  task automatic wr(input logic [15:0] off, input logic [7:0] d);
    cyc(1'b1, BASE + off, d, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [15:0] off);
    cyc(1'b1, BASE + off, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, BASE + 16'h0100, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rand_off();
    int unsigned p;
    p = $urandom_range(0, 9);
    if (p == 0) return 16'h0000;
    if (p == 9) return 16'($urandom);
    return 16'(8 + 8 * $urandom_range(0, NCH - 1) + $urandom_range(0, 7));
  endfunction

  function automatic logic [7:0] rand_data(input logic [15:0] off);
    if (off >= 8 && off[2:0] == 3'd4)
      return {2'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 1))};
    if ($urandom_range(0, 3) == 0) return 8'hff - 8'($urandom_range(0, 2));
    return 8'($urandom);
  endfunction

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [15:0] off;
    int unsigned p;

    // Reset with stray bus writes that must be ignored.
    for (int i = 0; i < 3; i++) cyc(1'b0, BASE + rand_off(), 8'($urandom), 1'b0, 1'b1);
    for (int c = -1; c < NCH; c++) begin
      for (int r = 0; r < 6; r++) begin
        off = (c < 0) ? 16'h0000 : 16'(8 + 8 * c + r);
        rd(off);
        check("rst_rd_w8", {8'd0, out8}, 16'h0000);
        check("rst_rd_w16", {8'd0, out16}, 16'h0000);
        check("rst_irq", {14'd0, irq8, irq16}, 16'h0000);
        if (c < 0) break;
      end
    end

    // Channel 0: SEL=1, EN, IRQEN; fe -> ff -> overflow to 40.
    wr(16'd8, 8'hfe);
    wr(16'd10, 8'h40);
    wr(16'd0, 8'h00);
    wr(16'd12, 8'h29);
    idle(14);
    rd(16'd8);
    check("ch0_cnt_ff", {8'd0, out8}, 16'h00ff);
    idle(15);
    rd(16'd8);
    check("ch0_cnt_reload", {8'd0, out8}, 16'h0040);
    check("ch0_irq_set", {15'd0, irq8}, 16'h0001);
    wr(16'd13, 8'h01);
    check("ch0_irq_clr", {15'd0, irq8}, 16'h0000);

    // Channel 1: one-shot overflow ffff -> 1234 after 4 cycles.
    wr(16'd16, 8'hff);
    wr(16'd17, 8'hff);
    wr(16'd18, 8'h34);
    wr(16'd19, 8'h12);
    wr(16'd0, 8'h00);
    wr(16'd20, 8'h18);
    idle(2);
    rd(16'd16);
    check("ch1_oneshot_lo", {8'd0, out16}, 16'h0034);
    rd(16'd20);
    check("ch1_ctrl_en_clr", {8'd0, out16}, 16'h0010);
    rd(16'd17);
    check("ch1_oneshot_hi", {8'd0, out16}, 16'h0012);
    idle(8);
    rd(16'd16);
    check("ch1_hold", {8'd0, out16}, 16'h0034);

    // Overflow coinciding with W1C keeps pending.
    wr(16'd0, 8'h00);
    wr(16'd8, 8'hff);
    idle(14);
    wr(16'd13, 8'h01);
    rd(16'd13);
    check("ovf_beats_w1c", {8'd0, out8}, 16'h0001);

    // CNT_LO write coinciding with a would-be overflow tick wins.
    wr(16'd0, 8'h00);
    wr(16'd13, 8'h01);
    wr(16'd8, 8'hff);
    idle(13);
    wr(16'd8, 8'h55);
    rd(16'd8);
    check("wr_beats_tick", {8'd0, out8}, 16'h0055);
    rd(16'd13);
    check("wr_no_pend", {8'd0, out8}, 16'h0000);

    // DIV write while tapped bit 1 is set.
    wr(16'd0, 8'h00);
    wr(16'd20, 8'h08);
    wr(16'd16, 8'h10);
    wr(16'd0, 8'h00);
    rd(16'd0);
    check("div_cleared", {8'd0, out8}, 16'h0000);
    rd(16'd16);
    check("div_glitch", {8'd0, out8}, GLITCH ? 16'h0011 : 16'h0010);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      p   = $urandom_range(0, 99);
      off = rand_off();
      if (p < 2)       cyc(1'b0, BASE + off, 8'($urandom), 1'b0, 1'b1);
      else if (p < 40) wr(off, rand_data(off));
      else if (p < 44) wr(16'd0, 8'($urandom));
      else if (p < 75) rd(off);
      else             idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
